// File: rtl/sram_1rw1r_param.sv
`default_nettype none
// ============================================================================
// Module   : sram_1rw1r_param
// Brief    : Parametrised 1RW + 1R single-clock SRAM model with byte write
//            masks, registered read outputs with valid strobes, selectable
//            read-during-write collision policy and optional zero-fill sweep.
// Revision : 1.0 - initial release
// ============================================================================
module sram_1rw1r_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int COLLISION_MODE = 1,
  parameter int INIT_ON_RESET  = 1,
  parameter int VERBOSE        = 0
) (
  input  logic                      clk0,
  input  logic                      rst_n,
  input  logic                      csb0,
  input  logic                      web0,
  input  logic [DATA_WIDTH/8-1:0]   wmask0,
  input  logic [ADDR_WIDTH-1:0]     addr0,
  input  logic [DATA_WIDTH-1:0]     din0,
  output logic [DATA_WIDTH-1:0]     dout0,
  output logic                      dout0_valid,
  input  logic                      csb1,
  input  logic [ADDR_WIDTH-1:0]     addr1,
  output logic [DATA_WIDTH-1:0]     dout1,
  output logic                      dout1_valid,
  output logic                      collision,
  output logic                      init_busy
);

  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } init_state_t;

  // Where the sweep FSM lands while reset is held.
  localparam init_state_t c_rst_state = (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;

  // Reject parameter sets the datapath cannot represent. VERBOSE only steers
  // simulation diagnostics, so it is range-checked here and nowhere else.
  if ((DATA_WIDTH <= 0) || ((DATA_WIDTH % 8) != 0) ||
      (COLLISION_MODE < 0) || (COLLISION_MODE > 1) ||
      (INIT_ON_RESET < 0) || (INIT_ON_RESET > 1) ||
      (VERBOSE < 0) || (VERBOSE > 1)) begin : g_bad_param
    $error("sram_1rw1r_param: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  init_state_t             r_state;
  init_state_t             w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_init_ptr;
  logic [ADDR_WIDTH-1:0]   w_init_ptr_nxt;

  logic                    w_active;
  logic                    w_ctl0_known;
  logic                    w_ctl1_known;
  logic                    w_wr0;
  logic                    w_rd0;
  logic                    w_rd1;
  logic                    w_same;
  logic [DATA_WIDTH-1:0]   w_rdata0;
  logic [DATA_WIDTH-1:0]   w_rdata1;
  logic [DATA_WIDTH-1:0]   w_merged;
  logic [DATA_WIDTH-1:0]   w_dout1_nxt;

  assign init_busy = (r_state == ST_INIT);

  // User traffic is only honoured out of reset and once the sweep is done.
  // Unknown control bits deselect the port rather than corrupting memory.
  assign w_active     = rst_n && !init_busy;
  assign w_ctl0_known = !$isunknown({csb0, web0});
  assign w_ctl1_known = !$isunknown(csb1);

  assign w_wr0 = w_active && w_ctl0_known && !csb0 && !web0;
  assign w_rd0 = w_active && w_ctl0_known && !csb0 &&  web0;
  assign w_rd1 = w_active && w_ctl1_known && !csb1;

  assign w_rdata0 = mem[addr0];
  assign w_rdata1 = mem[addr1];

  // Byte-lane merge of the write data over the currently stored word.
  for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane
    assign w_merged[8*i +: 8] = wmask0[i] ? din0[8*i +: 8] : w_rdata0[8*i +: 8];
  end

  // Port 1 sees either the pre-write word or the merged word on a same-address hit.
  assign w_same      = w_wr0 && w_rd1 && (addr0 == addr1);
  assign w_dout1_nxt = (w_same && (COLLISION_MODE != 0)) ? w_merged : w_rdata1;

  // Sweep state and pointer; reset mid-sweep restarts from word 0.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_rst_state;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  // Sweep next-state: leave INIT right after the last word is cleared.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    case (r_state)
      ST_INIT: begin
        w_init_ptr_nxt = r_init_ptr + 1'b1;
        if (r_init_ptr == {ADDR_WIDTH{1'b1}}) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_init_ptr_nxt = '0;
      end
    endcase
  end

  // Storage array: sweep zero-fill has priority, user writes otherwise.
  always_ff @(posedge clk0) begin
    if (init_busy) begin
      mem[r_init_ptr] <= '0;
    end else if (w_wr0) begin
      mem[addr0] <= w_merged;
    end
  end

  // Registered read data, valid strobes and collision flag.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      dout0       <= '0;
      dout0_valid <= 1'b0;
      dout1       <= '0;
      dout1_valid <= 1'b0;
      collision   <= 1'b0;
    end else begin
      dout0_valid <= w_rd0;
      dout1_valid <= w_rd1;
      collision   <= w_same;
      if (w_rd0) begin
        dout0 <= w_rdata0;
      end
      if (w_rd1) begin
        dout1 <= w_dout1_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw1r_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_1rw1r_param
// Brief    : Self-checking bench for sram_1rw1r_param. Three instances share
//            stimulus: collision-new/zero-fill, collision-old/zero-fill and
//            collision-new/no-fill. A word-level model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_1rw1r_param;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int NI = 3;

  logic          clk0 = 1'b0;
  logic          rst_n;
  logic          csb0, web0, csb1;
  logic [3:0]    wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;

  logic [DW-1:0] d0 [NI];
  logic [DW-1:0] d1 [NI];
  logic [NI-1:0] v0, v1, col, busy;

  always #5 clk0 = ~clk0;

  sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COLLISION_MODE(1),
                     .INIT_ON_RESET(1), .VERBOSE(0)) u_new (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(d0[0]), .dout0_valid(v0[0]),
    .csb1(csb1), .addr1(addr1), .dout1(d1[0]), .dout1_valid(v1[0]),
    .collision(col[0]), .init_busy(busy[0]));

  sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COLLISION_MODE(0),
                     .INIT_ON_RESET(1), .VERBOSE(0)) u_old (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(d0[1]), .dout0_valid(v0[1]),
    .csb1(csb1), .addr1(addr1), .dout1(d1[1]), .dout1_valid(v1[1]),
    .collision(col[1]), .init_busy(busy[1]));

  sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COLLISION_MODE(1),
                     .INIT_ON_RESET(0), .VERBOSE(0)) u_nofill (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(d0[2]), .dout0_valid(v0[2]),
    .csb1(csb1), .addr1(addr1), .dout1(d1[2]), .dout1_valid(v1[2]),
    .collision(col[2]), .init_busy(busy[2]));

  // Reference model: per-instance word array with "known" flags, a sweep
  // countdown and the expected registered outputs.
  int          cm_new [NI] = '{1, 0, 1};
  int          fills  [NI] = '{1, 1, 0};
  logic [31:0] mm     [NI][DEPTH];
  bit          kn     [NI][DEPTH];
  int          busy_left [NI];
  logic [31:0] e_d0 [NI];
  logic [31:0] e_d1 [NI];
  bit          e_d0k [NI];
  bit          e_d1k [NI];
  bit          e_v0 [NI];
  bit          e_v1 [NI];
  bit          e_col [NI];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      e_d0[k] = '0; e_d1[k] = '0; e_d0k[k] = 1'b1; e_d1k[k] = 1'b1;
      e_v0[k] = 1'b0; e_v1[k] = 1'b0; e_col[k] = 1'b0;
      if (fills[k] != 0) begin
        busy_left[k] = DEPTH;
        for (int a = 0; a < DEPTH; a++) begin
          mm[k][a] = '0;
          kn[k][a] = 1'b1;
        end
      end else begin
        busy_left[k] = 0;
      end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < NI; k++) begin
      logic [31:0] old0;
      logic [31:0] mrg;
      bit ok0, mk, wr, rd0, rd1;
      if (!rst_n) continue;
      e_v0[k] = 1'b0; e_v1[k] = 1'b0; e_col[k] = 1'b0;
      if (busy_left[k] > 0) begin
        busy_left[k]--;
        continue;
      end
      wr  = !csb0 && !web0;
      rd0 = !csb0 && web0;
      rd1 = !csb1;
      old0 = mm[k][addr0];
      ok0  = kn[k][addr0];
      for (int b = 0; b < 4; b++)
        mrg[8*b +: 8] = wmask0[b] ? din0[8*b +: 8] : old0[8*b +: 8];
      mk = ok0 || (wmask0 == 4'hF);
      if (rd0) begin
        e_v0[k] = 1'b1; e_d0[k] = old0; e_d0k[k] = ok0;
      end
      if (rd1) begin
        e_v1[k] = 1'b1;
        if (wr && addr0 == addr1) begin
          e_col[k] = 1'b1;
          if (cm_new[k] != 0) begin e_d1[k] = mrg;  e_d1k[k] = mk;  end
          else                begin e_d1[k] = old0; e_d1k[k] = ok0; end
        end else begin
          e_d1[k] = mm[k][addr1]; e_d1k[k] = kn[k][addr1];
        end
      end
      if (wr) begin
        mm[k][addr0] = mrg;
        kn[k][addr0] = mk;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk("init_busy",   k, 32'(busy[k]), 32'(busy_left[k] > 0));
      chk("dout0_valid", k, 32'(v0[k]),   32'(e_v0[k]));
      chk("dout1_valid", k, 32'(v1[k]),   32'(e_v1[k]));
      chk("collision",   k, 32'(col[k]),  32'(e_col[k]));
      if (e_d0k[k]) chk("dout0", k, d0[k], e_d0[k]);
      if (e_d1k[k]) chk("dout1", k, d1[k], e_d1[k]);
    end
  endtask

  task automatic cyc();
    @(posedge clk0);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
  endtask

  task automatic rand_req();
    csb0   = ($urandom_range(0, 3) == 0);
    web0   = ($urandom_range(0, 1) == 0);
    csb1   = ($urandom_range(0, 3) == 0);
    wmask0 = 4'($urandom_range(0, 15));
    addr0  = 4'($urandom_range(0, 15));
    addr1  = ($urandom_range(0, 2) == 0) ? addr0 : 4'($urandom_range(0, 15));
    din0   = $urandom;
  endtask

  task automatic reset_on();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    for (int k = 0; k < NI; k++)
      for (int a = 0; a < DEPTH; a++) kn[k][a] = 1'b0;
    rst_n = 1'b1;
    idle();
    #2;
    reset_on();
    repeat (3) cyc();

    // Sweep length after release.
    rst_n = 1'b1;
    bc = 0;
    while (busy[0] === 1'b1 && bc < 40) begin cyc(); bc++; end
    chk("sweep_len", 0, 32'(bc), 32'd16);

    // Every word reads back zero on both ports, one cycle after request.
    for (int a = 0; a < DEPTH; a++) begin
      csb0 = 1'b0; web0 = 1'b1; addr0 = 4'(a); csb1 = 1'b0; addr1 = 4'(a);
      cyc();
      chk("zero_rd0", 0, d0[0], 32'h0);
      chk("zero_rd1", 1, d1[1], 32'h0);
    end
    idle();

    // Byte-masked write merge.
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd3; din0 = 32'hAABBCCDD; wmask0 = 4'b1111;
    cyc();
    din0 = 32'h11223344; wmask0 = 4'b0101;
    cyc();
    chk("wr_no_valid", 0, 32'(v0[0]), 32'd0);
    idle(); csb1 = 1'b0; addr1 = 4'd3;
    cyc();
    chk("mask_merge", 0, d1[0], 32'hAA22CC44);

    // Same-address collision in both policies, then a different address.
    idle();
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5; din0 = 32'hDEADBEEF; wmask0 = 4'b1111;
    csb1 = 1'b0; addr1 = 4'd5;
    cyc();
    chk("coll_new_data", 0, d1[0], 32'hDEADBEEF);
    chk("coll_new_flag", 0, 32'(col[0]), 32'd1);
    chk("coll_old_data", 1, d1[1], 32'h0);
    chk("coll_old_flag", 1, 32'(col[1]), 32'd1);
    addr1 = 4'd6;
    cyc();
    chk("no_coll_flag", 0, 32'(col[0]), 32'd0);

    // Read once, then deselect: outputs hold, valids stay low.
    idle();
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5; csb1 = 1'b0; addr1 = 4'd3;
    cyc();
    idle();
    repeat (4) begin
      cyc();
      chk("hold_d0", 0, d0[0], 32'hDEADBEEF);
      chk("hold_d1", 0, d1[0], 32'hAA22CC44);
      chk("hold_v0", 0, 32'(v0[0]), 32'd0);
    end

    // Reset at sweep cycle 7, with requests active during the sweep.
    reset_on();
    cyc();
    rst_n = 1'b1;
    repeat (7) begin rand_req(); cyc(); end
    reset_on();
    chk("rst_dout0", 0, d0[0], 32'h0);
    cyc();
    rst_n = 1'b1;
    bc = 0;
    while (busy[0] === 1'b1 && bc < 40) begin rand_req(); cyc(); bc++; end
    chk("resweep_len", 0, 32'(bc), 32'd16);
    idle(); csb1 = 1'b0; addr1 = 4'd5;
    cyc();
    chk("refill_zero", 0, d1[0], 32'h0);

    // No-fill instance keeps content across reset.
    idle();
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd2; din0 = 32'h12345678; wmask0 = 4'b1111;
    cyc();
    idle();
    reset_on();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("nofill_busy", 2, 32'(busy[2]), 32'd0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd2;
    cyc();
    chk("nofill_keep", 2, d0[2], 32'h12345678);
    idle();
    repeat (DEPTH) cyc();

    // Randomised traffic against the model.
    repeat (400) begin rand_req(); cyc(); end
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
